// File: rtl/video_mem_responder.sv
// video_mem_responder
//
// Memory-side responder for the PPU fetch port and the CPU bus. Holds VRAM
// ($8000 based, VRAM_DEPTH bytes) and OAM ($FE00 based, OAM_DEPTH bytes).
// The PPU always wins. A CPU access colliding with a PPU access to the same
// memory is parked in a one-entry hold register until that memory is free.
//
// Optional feature macro: VIDEO_MEM_LOCK_EN. When defined, CPU access is locked
// out by PPU mode while the LCD is on (mode 2: OAM locked, mode 3: OAM and VRAM
// locked). A locked read returns $FF and a locked write is dropped.
//
// Ports:
//   clk_in        system clock
//   rst_in        asynchronous active-low reset
//   tclk_in       T-cycle enable; accesses are accepted only when high
//   mode_in       PPU mode (0 HBlank, 1 VBlank, 2 OAMScan, 3 Draw)
//   lcd_en_in     LCDC bit 7
//   ppu_addr_in   PPU read address
//   ppu_req_in    PPU read request
//   ppu_data_out  PPU read data, held until the next PPU response
//   ppu_valid_out PPU data valid, one-clk pulse
//   cpu_addr_in   CPU address
//   cpu_rd_in     CPU read strobe
//   cpu_wr_in     CPU write strobe (wins over cpu_rd_in)
//   cpu_wdata_in  CPU write data
//   cpu_rdata_out CPU read data, held until the next CPU read response
//   cpu_valid_out CPU access complete, one-clk pulse
//   cpu_busy_out  a CPU access is parked; new CPU requests are ignored
module video_mem_responder #(
  parameter int unsigned VRAM_DEPTH = 8192,
  parameter int unsigned OAM_DEPTH  = 160
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic [1:0]  mode_in,
  input  logic        lcd_en_in,
  input  logic [15:0] ppu_addr_in,
  input  logic        ppu_req_in,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_valid_out,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_rd_in,
  input  logic        cpu_wr_in,
  input  logic [7:0]  cpu_wdata_in,
  output logic [7:0]  cpu_rdata_out,
  output logic        cpu_valid_out,
  output logic        cpu_busy_out
);

  localparam int unsigned VramAw = (VRAM_DEPTH > 1) ? $clog2(VRAM_DEPTH) : 1;
  localparam int unsigned OamAw  = (OAM_DEPTH > 1) ? $clog2(OAM_DEPTH) : 1;

  logic [7:0] vram [VRAM_DEPTH];
  logic [7:0] oam  [OAM_DEPTH];

  logic        hold_valid_q;
  logic [15:0] hold_addr_q;
  logic        hold_wr_q;
  logic [7:0]  hold_wdata_q;

  logic [7:0]  ppu_data_q, cpu_rdata_q;
  logic        ppu_valid_q, cpu_valid_q;

  logic [15:0] ppu_voff, ppu_ooff, cpu_voff, cpu_ooff;
  logic [15:0] cpu_addr_sel;
  logic        cpu_wr_sel;
  logic [7:0]  cpu_wdata_sel;
  logic        ppu_vhit, ppu_ohit, cpu_vhit, cpu_ohit;
  logic        ppu_acc, cpu_req, same_mem, cpu_locked;
  logic        cpu_hold_set, cpu_serve, cpu_wen;
  logic [7:0]  ppu_rdata, cpu_rdata;

  // A parked access takes over the CPU datapath; live CPU strobes are ignored.
  always_comb begin
    cpu_addr_sel  = hold_valid_q ? hold_addr_q  : cpu_addr_in;
    cpu_wr_sel    = hold_valid_q ? hold_wr_q    : cpu_wr_in;
    cpu_wdata_sel = hold_valid_q ? hold_wdata_q : cpu_wdata_in;

    // Offsets wrap below the base, so a single unsigned compare decodes range.
    ppu_voff = ppu_addr_in - 16'h8000;
    ppu_ooff = ppu_addr_in - 16'hFE00;
    cpu_voff = cpu_addr_sel - 16'h8000;
    cpu_ooff = cpu_addr_sel - 16'hFE00;
    ppu_vhit = 32'(ppu_voff) < VRAM_DEPTH;
    ppu_ohit = 32'(ppu_ooff) < OAM_DEPTH;
    cpu_vhit = 32'(cpu_voff) < VRAM_DEPTH;
    cpu_ohit = 32'(cpu_ooff) < OAM_DEPTH;
  end

`ifdef VIDEO_MEM_LOCK_EN
  assign cpu_locked = lcd_en_in && (((mode_in == 2'd2) && cpu_ohit) ||
                                    ((mode_in == 2'd3) && (cpu_ohit || cpu_vhit)));
`else
  logic unused_lock;
  assign unused_lock = ^{mode_in, lcd_en_in};
  assign cpu_locked  = 1'b0;
`endif

  always_comb begin
    ppu_acc  = tclk_in && ppu_req_in;
    cpu_req  = tclk_in && (hold_valid_q ||
                           ((cpu_rd_in || cpu_wr_in) && (cpu_vhit || cpu_ohit)));
    same_mem = (ppu_vhit && cpu_vhit) || (ppu_ohit && cpu_ohit);

    // A new locked access never needs the memory, so it completes at once.
    // A parked access waits for its memory regardless of lock state.
    cpu_hold_set = cpu_req && !hold_valid_q && ppu_acc && same_mem && !cpu_locked;
    cpu_serve    = cpu_req && !(ppu_acc && same_mem && (hold_valid_q || !cpu_locked));
    cpu_wen      = rst_in && cpu_serve && cpu_wr_sel && !cpu_locked;

    if (ppu_vhit)      ppu_rdata = vram[ppu_voff[VramAw-1:0]];
    else if (ppu_ohit) ppu_rdata = oam[ppu_ooff[OamAw-1:0]];
    else               ppu_rdata = 8'hFF;

    if (cpu_locked)    cpu_rdata = 8'hFF;
    else if (cpu_vhit) cpu_rdata = vram[cpu_voff[VramAw-1:0]];
    else               cpu_rdata = oam[cpu_ooff[OamAw-1:0]];
  end

  // RAM contents survive reset.
  always_ff @(posedge clk_in) begin
    if (cpu_wen) begin
      if (cpu_vhit) vram[cpu_voff[VramAw-1:0]] <= cpu_wdata_sel;
      else          oam[cpu_ooff[OamAw-1:0]]   <= cpu_wdata_sel;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ppu_data_q   <= 8'h00;
      ppu_valid_q  <= 1'b0;
      cpu_rdata_q  <= 8'h00;
      cpu_valid_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= 16'h0000;
      hold_wr_q    <= 1'b0;
      hold_wdata_q <= 8'h00;
    end else begin
      ppu_valid_q <= ppu_acc;
      if (ppu_acc) ppu_data_q <= ppu_rdata;
      cpu_valid_q <= cpu_serve;
      if (cpu_serve && !cpu_wr_sel) cpu_rdata_q <= cpu_rdata;
      if (cpu_hold_set) begin
        hold_valid_q <= 1'b1;
        hold_addr_q  <= cpu_addr_in;
        hold_wr_q    <= cpu_wr_in;
        hold_wdata_q <= cpu_wdata_in;
      end else if (cpu_serve) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  assign ppu_data_out  = ppu_data_q;
  assign ppu_valid_out = ppu_valid_q;
  assign cpu_rdata_out = cpu_rdata_q;
  assign cpu_valid_out = cpu_valid_q;
  assign cpu_busy_out  = hold_valid_q;

endmodule

// File: doc/video_mem_responder.md
# video_mem_responder

- Memory-side responder for the pixel processing unit's fetch interface.
- Holds VRAM (`$8000-$9FFF`) and OAM (`$FE00-$FE9F`), and answers PPU byte reads with `data`/`valid`.
- Also services a CPU read/write port, with per-mode access lockout and same-memory collision arbitration.
- Sits between the PPU fetch port (OAM scan, tile/sprite fetch) and the CPU bus decoder.

## Interface

Parameters:

- `VRAM_DEPTH`, default 8192: VRAM bytes, based at `$8000`.
- `OAM_DEPTH`, default 160: OAM bytes, based at `$FE00`.

Ports:

- `clk_in`, input, 1: system clock. Single clock domain.
- `rst_in`, input, 1: reset, asynchronous, active-low.
- `tclk_in`, input, 1: T-cycle enable; accesses are accepted only on `clk_in` edges where this is high.
- `mode_in`, input, 2: PPU mode (0 HBlank, 1 VBlank, 2 OAMScan, 3 Draw).
- `lcd_en_in`, input, 1: LCDC bit 7.
- `ppu_addr_in`, input, 16: PPU read address.
- `ppu_req_in`, input, 1: PPU read request.
- `ppu_data_out`, output, 8: PPU read data.
- `ppu_valid_out`, output, 1: PPU data valid, one-clk pulse.
- `cpu_addr_in`, input, 16: CPU address.
- `cpu_rd_in`, input, 1: CPU read strobe.
- `cpu_wr_in`, input, 1: CPU write strobe.
- `cpu_wdata_in`, input, 8: CPU write data.
- `cpu_rdata_out`, output, 8: CPU read data.
- `cpu_valid_out`, output, 1: CPU access complete, one-clk pulse (reads and writes).
- `cpu_busy_out`, output, 1: CPU request held and pending; new CPU requests are ignored while high.

## Operation

Address decode:

- VRAM hit: `addr - $8000 < VRAM_DEPTH`.
- OAM hit: `addr - $FE00 < OAM_DEPTH`.
- PPU request that misses both ranges is still answered: data `$FF`, valid pulsed.
- CPU request that misses both ranges is ignored: no valid, no state change.

Accept rules:

- The PPU request is accepted whenever `tclk_in && ppu_req_in`. The PPU always has priority.
- A CPU request is accepted when `tclk_in && (cpu_rd_in || cpu_wr_in) && !cpu_busy_out`.
- If rd and wr are both asserted, the access is treated as a write.

Lockout (only when `lcd_en_in`=1):

- mode 2: OAM locked.
- mode 3: OAM and VRAM locked.
- Locked CPU read returns `$FF`; locked CPU write is dropped. Both still pulse `cpu_valid_out`.
- Lock is evaluated at service time, not at request time.

Collision:

- A collision is an accepted PPU request and an accepted CPU request to the same memory (VRAM or OAM) in the same enabled cycle, with the CPU access not locked.
- The PPU is served. The CPU request (addr, rd/wr, wdata) is captured in a one-entry hold register and `cpu_busy_out` goes high.

Hold register:

- Serviced on the first later `tclk_in` cycle with no PPU request to that same memory.
- Lock is re-evaluated at that point. If the mode has become locked, the held access completes as a locked access (`$FF` / dropped write).

Other cases:

- CPU and PPU accessing different memories in the same cycle are both served that cycle.
- Reset:
  - Outputs go to 0 (`ppu_data_out`=`$00`, `cpu_rdata_out`=`$00`, valids 0, `cpu_busy_out` 0).
  - The hold register is cleared and any pending CPU access is discarded.
  - RAM contents are not cleared.

## Timing

- Latency: data and valid are registered and appear on the clk edge after the accepting edge. Valid is high for exactly one clk.
- Data outputs hold their last value until the next response.
- Held CPU access completes on the clk after its service edge. `cpu_busy_out` falls on that same edge as `cpu_valid_out` rises.
- Back-to-back PPU requests on consecutive enabled cycles give one response per enabled cycle. There is no throughput limit.
- Write then read of the same address on the next enabled cycle returns the new data.
- Asynchronous reset mid-access: the response in flight is suppressed; no valid is pulsed after reset deasserts.

## Configuration

- `VIDEO_MEM_LOCK_EN` defined: the mode-based CPU lockout described above is compiled in.
- Undefined:
  - No lockout; every in-range CPU access is serviced regardless of `mode_in` and `lcd_en_in`.
  - Collision hold and arbitration are unchanged.

## Test plan

- CPU write `$8010`←`$5A` in mode 0, then PPU read `$8010` -> `ppu_valid_out` one clk after accept, `ppu_data_out`=`$5A`.
- `VIDEO_MEM_LOCK_EN`, `lcd_en_in`=1, mode 2: CPU read `$FE00` -> `cpu_rdata_out`=`$FF`, valid pulse. Mode 3: CPU write `$8000`←`$11` -> dropped; later mode-0 read returns the prior value.
- PPU read `$FE04` and CPU write `$FE08`←`$22` in the same enabled cycle, mode 0 -> PPU served, `cpu_busy_out`=1. Next enabled cycle with no OAM PPU request -> write done, valid pulse, busy 0; read `$FE08` returns `$22`.
- Held CPU write to OAM while mode changes 0→2 before service -> write dropped, valid still pulses.
- PPU read `$C000` -> `$FF` with valid. CPU read `$C000` -> no valid.
- Assert `rst_in` low while `cpu_busy_out`=1 -> all outputs 0 immediately. After release no CPU valid appears; RAM retains `$5A` at `$8010`.
